// File: rtl/ibex_csr_access_sched.sv
// ---------------------------------------------------------------------------
// ibex_csr_access_sched
//
// Arbitrates CSR file accesses between the ID-stage CSR instruction path
// (core) and the debug-module abstract-command path (dbg). Each granted
// request runs IDLE -> RD -> WR -> RSP: RD samples the pre-write value and
// the illegal flag, WR commits the write only for legal non-READ ops, and
// RSP holds the response until the consumer accepts it.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   core_req_i/gnt_o/addr_i/...      core request channel (op: 0=RD 1=WR 2=SET 3=CLR)
//   dbg_req_i/gnt_o/addr_i/...       debug request channel (same op encoding)
//   rsp_valid_o/ready_i/src_o/...    response channel (src: 0=core, 1=dbg)
//   csr_access_o/addr_o/wdata_o/...  CSR file access interface
//   csr_rdata_i, illegal_csr_insn_i  CSR file combinational read data / illegal flag
//   busy_o                           FSM not in IDLE
//
// Optional feature: define IBEX_CSR_SCHED_PERF_EN to add the wrapping 16-bit
// counters core_grant_cnt_o, dbg_grant_cnt_o and starve_force_cnt_o.
// ---------------------------------------------------------------------------
module ibex_csr_access_sched #(
    parameter int unsigned StarveLimit = 4,
    parameter int unsigned CsrAddrW    = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                core_req_i,
    output logic                core_gnt_o,
    input  logic [CsrAddrW-1:0] core_addr_i,
    input  logic [31:0]         core_wdata_i,
    input  logic [1:0]          core_op_i,
    input  logic                dbg_req_i,
    output logic                dbg_gnt_o,
    input  logic [CsrAddrW-1:0] dbg_addr_i,
    input  logic [31:0]         dbg_wdata_i,
    input  logic [1:0]          dbg_op_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_src_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                csr_access_o,
    output logic [CsrAddrW-1:0] csr_addr_o,
    output logic [31:0]         csr_wdata_o,
    output logic [1:0]          csr_op_o,
    output logic                csr_op_en_o,
    input  logic [31:0]         csr_rdata_i,
    input  logic                illegal_csr_insn_i,
`ifdef IBEX_CSR_SCHED_PERF_EN
    output logic [15:0]         core_grant_cnt_o,
    output logic [15:0]         dbg_grant_cnt_o,
    output logic [15:0]         starve_force_cnt_o,
`endif
    output logic                busy_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StRsp  = 2'd3;

    localparam logic [1:0] OpRead = 2'd0;
    localparam logic [3:0] StarveLim = 4'(StarveLimit);

    logic [1:0]          state_q, state_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic [CsrAddrW-1:0] addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          op_q, op_d;
    logic                src_q, src_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic in_idle;
    logic starve_hit;
    logic dbg_win;

    // Grants are combinational from the requests; masked during reset so a
    // requester never sees a grant whose capture the reset would discard.
    assign in_idle    = (state_q == StIdle) && !rst_i;
    assign starve_hit = (starve_cnt_q == StarveLim);
    assign dbg_win    = dbg_req_i && (starve_hit || !core_req_i);
    assign core_gnt_o = in_idle && core_req_i && !dbg_win;
    assign dbg_gnt_o  = in_idle && dbg_win;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        src_d        = src_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            StIdle: begin
                if (dbg_gnt_o) begin
                    state_d = StRd;
                    addr_d  = dbg_addr_i;
                    wdata_d = dbg_wdata_i;
                    op_d    = dbg_op_i;
                    src_d   = 1'b1;
                end else if (core_gnt_o) begin
                    state_d = StRd;
                    addr_d  = core_addr_i;
                    wdata_d = core_wdata_i;
                    op_d    = core_op_i;
                    src_d   = 1'b0;
                end
                // Counter only tracks cycles where dbg is actually waiting.
                if (dbg_gnt_o || !dbg_req_i) begin
                    starve_cnt_d = '0;
                end else if (core_gnt_o && !starve_hit) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
            StRd: begin
                rdata_d = csr_rdata_i;
                err_d   = illegal_csr_insn_i;
                state_d = StWr;
            end
            StWr: begin
                state_d = StRsp;
            end
            default: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= '0;
            src_q        <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            src_q        <= src_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // CSR file drive: captured values only while RD/WR, zero otherwise.
    assign csr_access_o = (state_q == StRd) || (state_q == StWr);
    assign csr_addr_o   = csr_access_o ? addr_q  : '0;
    assign csr_wdata_o  = csr_access_o ? wdata_q : '0;
    assign csr_op_o     = csr_access_o ? op_q    : '0;
    assign csr_op_en_o  = (state_q == StWr) && (op_q != OpRead) && !err_q;

    assign rsp_valid_o = (state_q == StRsp);
    assign rsp_src_o   = rsp_valid_o && src_q;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign busy_o      = (state_q != StIdle);

`ifdef IBEX_CSR_SCHED_PERF_EN
    logic [15:0] core_grant_cnt_q, core_grant_cnt_d;
    logic [15:0] dbg_grant_cnt_q, dbg_grant_cnt_d;
    logic [15:0] starve_force_cnt_q, starve_force_cnt_d;

    always_comb begin
        core_grant_cnt_d   = core_grant_cnt_q + {15'd0, core_gnt_o};
        dbg_grant_cnt_d    = dbg_grant_cnt_q + {15'd0, dbg_gnt_o};
        starve_force_cnt_d = starve_force_cnt_q + {15'd0, dbg_gnt_o && starve_hit};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            core_grant_cnt_q   <= '0;
            dbg_grant_cnt_q    <= '0;
            starve_force_cnt_q <= '0;
        end else begin
            core_grant_cnt_q   <= core_grant_cnt_d;
            dbg_grant_cnt_q    <= dbg_grant_cnt_d;
            starve_force_cnt_q <= starve_force_cnt_d;
        end
    end

    assign core_grant_cnt_o   = core_grant_cnt_q;
    assign dbg_grant_cnt_o    = dbg_grant_cnt_q;
    assign starve_force_cnt_o = starve_force_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_csr_access_sched.sv
// ---------------------------------------------------------------------------
// tb_ibex_csr_access_sched
//
// Directed bench for ibex_csr_access_sched: single core write, illegal debug
// SET, core READ, response backpressure, starvation override, and reset in
// the middle of a transaction. Inputs change 1 ns after the rising edge and
// outputs are compared 1 ns later.
// ---------------------------------------------------------------------------
module tb_ibex_csr_access_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_gnt_o;
    logic [11:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic [1:0]  core_op_i;
    logic        dbg_req_i;
    logic        dbg_gnt_o;
    logic [11:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic [1:0]  dbg_op_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_src_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic        csr_op_en_o;
    logic [31:0] csr_rdata_i;
    logic        illegal_csr_insn_i;
    logic        busy_o;
`ifdef IBEX_CSR_SCHED_PERF_EN
    logic [15:0] core_grant_cnt_o;
    logic [15:0] dbg_grant_cnt_o;
    logic [15:0] starve_force_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    ibex_csr_access_sched #(.StarveLimit(4), .CsrAddrW(12)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .core_req_i         (core_req_i),
        .core_gnt_o         (core_gnt_o),
        .core_addr_i        (core_addr_i),
        .core_wdata_i       (core_wdata_i),
        .core_op_i          (core_op_i),
        .dbg_req_i          (dbg_req_i),
        .dbg_gnt_o          (dbg_gnt_o),
        .dbg_addr_i         (dbg_addr_i),
        .dbg_wdata_i        (dbg_wdata_i),
        .dbg_op_i           (dbg_op_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_src_o          (rsp_src_o),
        .rsp_rdata_o        (rsp_rdata_o),
        .rsp_err_o          (rsp_err_o),
        .csr_access_o       (csr_access_o),
        .csr_addr_o         (csr_addr_o),
        .csr_wdata_o        (csr_wdata_o),
        .csr_op_o           (csr_op_o),
        .csr_op_en_o        (csr_op_en_o),
        .csr_rdata_i        (csr_rdata_i),
        .illegal_csr_insn_i (illegal_csr_insn_i),
`ifdef IBEX_CSR_SCHED_PERF_EN
        .core_grant_cnt_o   (core_grant_cnt_o),
        .dbg_grant_cnt_o    (dbg_grant_cnt_o),
        .starve_force_cnt_o (starve_force_cnt_o),
`endif
        .busy_o             (busy_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge (input change point).
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle before comparing.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        core_req_i = 1'b0; core_addr_i = '0; core_wdata_i = '0; core_op_i = '0;
        dbg_req_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0; dbg_op_i = '0;
        rsp_ready_i = 1'b1; csr_rdata_i = '0; illegal_csr_insn_i = 1'b0;

        // ---------------- reset state
        cyc(); cyc();
        settle();
        check_val("rst_busy", busy_o, 0);
        check_val("rst_rsp_valid", rsp_valid_o, 0);
        check_val("rst_access", csr_access_o, 0);
        check_val("rst_op_en", csr_op_en_o, 0);
`ifdef IBEX_CSR_SCHED_PERF_EN
        check_val("rst_core_cnt", core_grant_cnt_o, 0);
        check_val("rst_dbg_cnt", dbg_grant_cnt_o, 0);
        check_val("rst_force_cnt", starve_force_cnt_o, 0);
`endif
        cyc();
        rst_i = 1'b0;

        // ---------------- core write
        core_req_i = 1'b1; core_op_i = 2'd1; core_addr_i = 12'h340;
        core_wdata_i = 32'hDEADBEEF; csr_rdata_i = 32'h11;
        settle();
        check_val("w_c0_core_gnt", core_gnt_o, 1);
        check_val("w_c0_dbg_gnt", dbg_gnt_o, 0);
        check_val("w_c0_op_en", csr_op_en_o, 0);
        cyc();                                  // RD
        core_req_i = 1'b0;
        settle();
        check_val("w_c1_access", csr_access_o, 1);
        check_val("w_c1_addr", csr_addr_o, 32'h340);
        check_val("w_c1_wdata", csr_wdata_o, 32'hDEADBEEF);
        check_val("w_c1_op", csr_op_o, 1);
        check_val("w_c1_op_en", csr_op_en_o, 0);
        check_val("w_c1_busy", busy_o, 1);
        cyc();                                  // WR
        settle();
        check_val("w_c2_op_en", csr_op_en_o, 1);
        check_val("w_c2_access", csr_access_o, 1);
        check_val("w_c2_rsp_valid", rsp_valid_o, 0);
        cyc();                                  // RSP
        settle();
        check_val("w_c3_rsp_valid", rsp_valid_o, 1);
        check_val("w_c3_rdata", rsp_rdata_o, 32'h11);
        check_val("w_c3_err", rsp_err_o, 0);
        check_val("w_c3_src", rsp_src_o, 0);
        check_val("w_c3_access", csr_access_o, 0);
        check_val("w_c3_addr", csr_addr_o, 0);
        check_val("w_c3_op_en", csr_op_en_o, 0);
        cyc();                                  // IDLE
        settle();
        check_val("w_c4_busy", busy_o, 0);
        check_val("w_c4_rsp_valid", rsp_valid_o, 0);

        // ---------------- illegal dbg SET
        dbg_req_i = 1'b1; dbg_op_i = 2'd2; dbg_addr_i = 12'h7B0; dbg_wdata_i = 32'h5;
        settle();
        check_val("ill_dbg_gnt", dbg_gnt_o, 1);
        check_val("ill_core_gnt", core_gnt_o, 0);
        cyc();                                  // RD
        dbg_req_i = 1'b0; illegal_csr_insn_i = 1'b1; csr_rdata_i = 32'h22;
        settle();
        check_val("ill_rd_op_en", csr_op_en_o, 0);
        check_val("ill_rd_op", csr_op_o, 2);
        cyc();                                  // WR: flag already registered
        illegal_csr_insn_i = 1'b0;
        settle();
        check_val("ill_wr_op_en", csr_op_en_o, 0);
        cyc();                                  // RSP
        settle();
        check_val("ill_rsp_err", rsp_err_o, 1);
        check_val("ill_rsp_src", rsp_src_o, 1);
        check_val("ill_rsp_rdata", rsp_rdata_o, 32'h22);
        cyc();                                  // IDLE

        // ---------------- core READ
        core_req_i = 1'b1; core_op_i = 2'd0; core_addr_i = 12'hF14;
        settle();
        check_val("rd_gnt", core_gnt_o, 1);
        cyc();                                  // RD
        core_req_i = 1'b0; csr_rdata_i = 32'h1234;
        settle();
        check_val("rd_rd_op_en", csr_op_en_o, 0);
        cyc();                                  // WR
        csr_rdata_i = 32'h9999;
        settle();
        check_val("rd_wr_op_en", csr_op_en_o, 0);
        cyc();                                  // RSP
        settle();
        check_val("rd_rsp_rdata", rsp_rdata_o, 32'h1234);
        check_val("rd_rsp_err", rsp_err_o, 0);
        cyc();                                  // IDLE

        // ---------------- backpressure
        core_req_i = 1'b1; core_op_i = 2'd1; core_addr_i = 12'h305; core_wdata_i = 32'hA5;
        settle();
        check_val("bp_gnt", core_gnt_o, 1);
        cyc();                                  // RD
        core_req_i = 1'b0; csr_rdata_i = 32'h77;
        cyc();                                  // WR
        rsp_ready_i = 1'b0;
        dbg_req_i = 1'b1; dbg_op_i = 2'd0; dbg_addr_i = 12'h7B1;
        settle();
        check_val("bp_wr_dbg_gnt", dbg_gnt_o, 0);
        cyc();                                  // RSP, stalled 5 cycles
        for (int k = 0; k < 5; k++) begin
            settle();
            check_val($sformatf("bp_hold%0d_valid", k), rsp_valid_o, 1);
            check_val($sformatf("bp_hold%0d_rdata", k), rsp_rdata_o, 32'h77);
            check_val($sformatf("bp_hold%0d_src", k), rsp_src_o, 0);
            check_val($sformatf("bp_hold%0d_dbg_gnt", k), dbg_gnt_o, 0);
            cyc();
        end
        rsp_ready_i = 1'b1;
        settle();
        check_val("bp_hs_valid", rsp_valid_o, 1);
        check_val("bp_hs_dbg_gnt", dbg_gnt_o, 0);
        cyc();                                  // IDLE after handshake
        settle();
        check_val("bp_next_dbg_gnt", dbg_gnt_o, 1);
        check_val("bp_next_busy", busy_o, 0);
        cyc();                                  // RD
        dbg_req_i = 1'b0;
        cyc(); cyc(); cyc();                    // WR, RSP, IDLE

        // ---------------- starvation (fresh reset clears the counter)
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        core_req_i = 1'b1; core_op_i = 2'd0;
        dbg_req_i = 1'b1; dbg_op_i = 2'd0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_val($sformatf("stv_arb%0d_core", i), core_gnt_o, (i != 4) ? 32'd1 : 32'd0);
            check_val($sformatf("stv_arb%0d_dbg", i), dbg_gnt_o, (i == 4) ? 32'd1 : 32'd0);
            cyc();                              // RD
            settle();
            check_val($sformatf("stv_arb%0d_nogntbusy", i), core_gnt_o | dbg_gnt_o, 0);
            cyc(); cyc(); cyc();                // WR, RSP, IDLE
        end
        core_req_i = 1'b0; dbg_req_i = 1'b0;
`ifdef IBEX_CSR_SCHED_PERF_EN
        settle();
        check_val("stv_core_cnt", core_grant_cnt_o, 5);
        check_val("stv_dbg_cnt", dbg_grant_cnt_o, 1);
        check_val("stv_force_cnt", starve_force_cnt_o, 1);
`endif

        // ---------------- reset during RD
        cyc();
        core_req_i = 1'b1; core_op_i = 2'd1; core_addr_i = 12'h300; core_wdata_i = 32'hFF;
        settle();
        check_val("mid_gnt", core_gnt_o, 1);
        cyc();                                  // RD
        core_req_i = 1'b0; rst_i = 1'b1;
        settle();
        check_val("mid_rd_access", csr_access_o, 1);
        cyc();
        settle();
        check_val("mid_busy", busy_o, 0);
        check_val("mid_op_en", csr_op_en_o, 0);
        check_val("mid_rsp_valid", rsp_valid_o, 0);
        check_val("mid_access", csr_access_o, 0);
`ifdef IBEX_CSR_SCHED_PERF_EN
        check_val("mid_core_cnt", core_grant_cnt_o, 0);
        check_val("mid_dbg_cnt", dbg_grant_cnt_o, 0);
        check_val("mid_force_cnt", starve_force_cnt_o, 0);
`endif
        rst_i = 1'b0;
        cyc();
        settle();
        check_val("mid_after_op_en", csr_op_en_o, 0);
        check_val("mid_after_busy", busy_o, 0);
        cyc();
        settle();
        check_val("mid_after2_op_en", csr_op_en_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
